fb_text_writer: RTL

//  Text-console writer: the write side of the glyph frame buffer that the VGA driver scans.
//  - Accepts one character per handshake and writes it at the cursor position.
//  - The buffer holds 80x60 glyphs, two 8-bit glyph codes per 16-bit word.
//  - Each write is a read-modify-write, so the other byte of the word is preserved.
//  - Handles the control characters newline, carriage return and backspace, plus a full-screen clear.

---
 rtl/fb_text_writer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/fb_text_writer.sv
// Write side of the 80x60 glyph frame buffer: places characters at the cursor with a
// read-modify-write of the shared 16-bit word, handles newline/CR/backspace and full clears.
`timescale 1ns/1ps
module fb_text_writer #(
    parameter int                    ADDR_WIDTH   = 16,
    parameter logic [ADDR_WIDTH-1:0] FB_START     = 16'h3000,
    parameter int                    SCREEN_WIDTH = 40,
    parameter int                    NUM_ROWS     = 60,
    parameter logic [7:0]            BLANK_GLYPH  = 8'h00
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            char_in,
    input  logic                  char_valid,
    output logic                  char_ready,
    input  logic                  clear_req,
    input  logic [15:0]           mem_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [15:0]           mem_in,
    output logic                  we,
    output logic [6:0]            cursor_col,
    output logic [5:0]            cursor_row
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_MERGE = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CLEAR = 3'd4;

    localparam int         CLEAR_WORDS = SCREEN_WIDTH * NUM_ROWS;
    localparam logic [11:0] CLEAR_LAST = 12'(CLEAR_WORDS - 1);
    localparam logic [6:0]  LAST_COL   = 7'(2 * SCREEN_WIDTH - 1);
    localparam logic [5:0]  LAST_ROW   = 6'(NUM_ROWS - 1);

    logic [2:0]            state;
    logic [7:0]            glyph;
    logic [11:0]           clear_cnt;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic [5:0]            next_row;

    assign char_ready = (state == S_IDLE);

    // Two glyphs share a word, so the column's upper bits pick the word and bit 0 the byte.
    always_comb begin
        word_addr = FB_START
                  + ADDR_WIDTH'(cursor_row) * ADDR_WIDTH'(SCREEN_WIDTH)
                  + ADDR_WIDTH'(cursor_col[6:1]);
        next_row  = (cursor_row == LAST_ROW) ? 6'd0 : cursor_row + 6'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            addr_out   <= FB_START;
            mem_in     <= '0;
            we         <= 1'b0;
            cursor_col <= '0;
            cursor_row <= '0;
            glyph      <= '0;
            clear_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (clear_req) begin
                        state     <= S_CLEAR;
                        addr_out  <= FB_START;
                        mem_in    <= {BLANK_GLYPH, BLANK_GLYPH};
                        we        <= 1'b1;
                        clear_cnt <= '0;
                    end else if (char_valid) begin
                        case (char_in)
                            8'h0A: begin
                                cursor_col <= '0;
                                cursor_row <= next_row;
                            end
                            8'h0D: cursor_col <= '0;
                            8'h08: begin
                                if (cursor_col != 7'd0)
                                    cursor_col <= cursor_col - 7'd1;
                            end
                            default: begin
                                glyph    <= char_in;
                                addr_out <= word_addr;
                                state    <= S_READ;
                            end
                        endcase
                    end
                end
                S_READ: state <= S_MERGE;
                S_MERGE: begin
                    // The RAM read issued in READ is visible now; keep the neighbouring glyph.
                    mem_in <= cursor_col[0] ? {mem_out[15:8], glyph} : {glyph, mem_out[7:0]};
                    we     <= 1'b1;
                    state  <= S_WRITE;
                end
                S_WRITE: begin
                    we    <= 1'b0;
                    state <= S_IDLE;
                    if (cursor_col == LAST_COL) begin
                        cursor_col <= '0;
                        cursor_row <= next_row;
                    end else begin
                        cursor_col <= cursor_col + 7'd1;
                    end
                end
                S_CLEAR: begin
                    if (clear_cnt == CLEAR_LAST) begin
                        we         <= 1'b0;
                        cursor_col <= '0;
                        cursor_row <= '0;
                        state      <= S_IDLE;
                    end else begin
                        addr_out  <= addr_out + 1'b1;
                        clear_cnt <= clear_cnt + 12'd1;
                    end
                end
                default: begin
                    we    <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
